// File: rtl/req_gnt_responder.sv
// Responder end of req/gnt: one-cycle grant MIN_LAT..MAX_LAT cycles after req is sampled, then a cooldown.
// stall defers the grant up to MAX_LAT only; en gates new acceptance; ok/err latch the first initiator violation.
module req_gnt_responder #(
  parameter int MIN_LAT     = 1,
  parameter int MAX_LAT     = 3,
  parameter int BUSY_CYCLES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             req,
  input  logic             stall,
  output logic             gnt,
  output logic             busy,
  output logic             ok,
  output logic             err,
  output logic [CNT_W-1:0] gnt_cnt
);

  localparam int LAT_W  = $clog2(MAX_LAT + 1);
  localparam int COOL_W = (BUSY_CYCLES > 0) ? $clog2(BUSY_CYCLES + 1) : 1;

  if (MIN_LAT < 1 || MIN_LAT > MAX_LAT || BUSY_CYCLES < 0) begin : g_param_check
    $error("req_gnt_responder: illegal MIN_LAT/MAX_LAT/BUSY_CYCLES");
  end

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT     = 2'd1,
    COOLDOWN = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [LAT_W-1:0]   lat, lat_nxt;
  logic [COOL_W-1:0]  cool, cool_nxt;
  logic [CNT_W-1:0]   gnt_cnt_nxt;
  logic               viol;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      lat     <= '0;
      cool    <= '0;
      ok      <= 1'b1;
      err     <= 1'b0;
      gnt_cnt <= '0;
    end else begin
      state   <= state_nxt;
      lat     <= lat_nxt;
      cool    <= cool_nxt;
      ok      <= ok & ~viol;
      err     <= err | viol;
      gnt_cnt <= gnt_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    lat_nxt   = lat;
    cool_nxt  = cool;
    gnt       = 1'b0;
    busy      = 1'b0;
    viol      = 1'b0;
    unique case (state)
      IDLE: begin
        if (en && req) begin
          state_nxt = WAIT;
          lat_nxt   = LAT_W'(1);
        end
      end
      WAIT: begin
        busy = 1'b1;
        // reaching MAX_LAT overrides stall so the latency bound always holds
        gnt  = req && ((lat >= LAT_W'(MIN_LAT) && !stall) || lat == LAT_W'(MAX_LAT));
        if (gnt) begin
          lat_nxt = '0;
          if (BUSY_CYCLES == 0) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = COOLDOWN;
            cool_nxt  = COOL_W'(BUSY_CYCLES);
          end
        end else if (!req) begin
          viol      = 1'b1;
          state_nxt = IDLE;
          lat_nxt   = '0;
        end else begin
          lat_nxt = lat + LAT_W'(1);
        end
      end
      COOLDOWN: begin
        busy     = 1'b1;
        cool_nxt = cool - COOL_W'(1);
        if (cool == COOL_W'(1)) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    gnt_cnt_nxt = gnt_cnt;
    if (gnt && gnt_cnt != {CNT_W{1'b1}}) begin
      gnt_cnt_nxt = gnt_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_req_gnt_responder.sv
// Bench for req_gnt_responder: three parameterisations driven by directed vectors,
// checked every cycle against a timestamp-based model plus literal expectations.
module tb_req_gnt_responder;

  localparam int N = 3;

  // instance 0: defaults; 1: MIN_LAT=2; 2: CNT_W=2 with no cooldown
  int p_min  [N] = '{1, 2, 1};
  int p_max  [N] = '{3, 3, 3};
  int p_busy [N] = '{2, 2, 0};
  int p_cntw [N] = '{8, 8, 2};

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] en_v    = 3'b000;
  logic [2:0] req_v   = 3'b000;
  logic [2:0] stall_v = 3'b000;
  logic [2:0] gnt_v, busy_v, ok_v, err_v;
  logic [7:0] cnt_a, cnt_b;
  logic [1:0] cnt_c;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  bit m_wait [N];
  bit m_ok   [N];
  int m_t0   [N];
  int m_cend [N];
  int m_cnt  [N];

  always #5 clk = ~clk;

  req_gnt_responder #(.MIN_LAT(1), .MAX_LAT(3), .BUSY_CYCLES(2), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en_v[0]), .req(req_v[0]), .stall(stall_v[0]),
    .gnt(gnt_v[0]), .busy(busy_v[0]), .ok(ok_v[0]), .err(err_v[0]), .gnt_cnt(cnt_a));

  req_gnt_responder #(.MIN_LAT(2), .MAX_LAT(3), .BUSY_CYCLES(2), .CNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en_v[1]), .req(req_v[1]), .stall(stall_v[1]),
    .gnt(gnt_v[1]), .busy(busy_v[1]), .ok(ok_v[1]), .err(err_v[1]), .gnt_cnt(cnt_b));

  req_gnt_responder #(.MIN_LAT(1), .MAX_LAT(3), .BUSY_CYCLES(0), .CNT_W(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .en(en_v[2]), .req(req_v[2]), .stall(stall_v[2]),
    .gnt(gnt_v[2]), .busy(busy_v[2]), .ok(ok_v[2]), .err(err_v[2]), .gnt_cnt(cnt_c));

  function automatic int dut_cnt(input int i);
    case (i)
      0:       return int'(cnt_a);
      1:       return int'(cnt_b);
      default: return int'(cnt_c);
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: a request sampled at cycle t0 may be granted at t0+k, MIN<=k<=MAX;
  // after a grant at g the responder is busy until cycle g+1+BUSY_CYCLES.
  function automatic bit exp_gnt(input int i);
    int k;
    k = cyc - m_t0[i];
    return rst_n && m_wait[i] && req_v[i] &&
           ((k >= p_min[i] && !stall_v[i]) || k == p_max[i]);
  endfunction

  function automatic bit exp_busy(input int i);
    return rst_n && (m_wait[i] || cyc < m_cend[i]);
  endfunction

  initial begin
    for (int i = 0; i < N; i++) begin
      m_wait[i] = 0; m_ok[i] = 1; m_t0[i] = 0; m_cend[i] = 0; m_cnt[i] = 0;
    end
    forever begin
      @(posedge clk);
      for (int i = 0; i < N; i++) begin
        if (!rst_n) begin
          m_wait[i] = 0; m_ok[i] = 1; m_cend[i] = 0; m_cnt[i] = 0;
        end else if (exp_gnt(i)) begin
          m_wait[i] = 0;
          m_cend[i] = cyc + 1 + p_busy[i];
          if (m_cnt[i] < (1 << p_cntw[i]) - 1) m_cnt[i] = m_cnt[i] + 1;
        end else if (m_wait[i] && !req_v[i]) begin
          m_wait[i] = 0;
          m_ok[i]   = 0;
        end else if (!m_wait[i] && cyc >= m_cend[i] && en_v[i] && req_v[i]) begin
          m_wait[i] = 1;
          m_t0[i]   = cyc;
        end
      end
      cyc++;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        check($sformatf("model gnt[%0d]", i),  int'(gnt_v[i]),  int'(exp_gnt(i)));
        check($sformatf("model busy[%0d]", i), int'(busy_v[i]), int'(exp_busy(i)));
        check($sformatf("model ok[%0d]", i),   int'(ok_v[i]),   rst_n ? int'(m_ok[i]) : 1);
        check($sformatf("model err[%0d]", i),  int'(err_v[i]),  rst_n ? int'(!m_ok[i]) : 0);
        check($sformatf("model cnt[%0d]", i),  dut_cnt(i),      rst_n ? m_cnt[i] : 0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", n_err);
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input logic [2:0] e, input logic [2:0] r, input logic [2:0] s);
    @(posedge clk);
    #1;
    en_v = e; req_v = r; stall_v = s;
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    check("reset gnt", int'(gnt_v[0]), 0);
    check("reset busy", int'(busy_v[0]), 0);
    check("reset ok", int'(ok_v[0]), 1);
    check("reset err", int'(err_v[0]), 0);
    check("reset cnt", int'(cnt_a), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick(3'b000, 3'b000, 3'b000);

    // clean transaction: gnt cycle 1, busy 1..3, idle at 4
    tick(3'b001, 3'b001, 3'b000);
    check("clean c0 gnt", int'(gnt_v[0]), 0);
    check("clean c0 busy", int'(busy_v[0]), 0);
    tick(3'b001, 3'b001, 3'b000);
    check("clean c1 gnt", int'(gnt_v[0]), 1);
    check("clean c1 busy", int'(busy_v[0]), 1);
    tick(3'b001, 3'b000, 3'b000);
    check("clean c2 gnt", int'(gnt_v[0]), 0);
    check("clean c2 busy", int'(busy_v[0]), 1);
    tick(3'b001, 3'b000, 3'b000);
    check("clean c3 busy", int'(busy_v[0]), 1);
    tick(3'b001, 3'b000, 3'b000);
    check("clean c4 busy", int'(busy_v[0]), 0);
    check("clean c4 cnt", int'(cnt_a), 1);
    check("clean c4 ok", int'(ok_v[0]), 1);

    // stall held: grant forced at MAX_LAT
    tick(3'b001, 3'b001, 3'b001);
    tick(3'b001, 3'b001, 3'b001);
    check("stall c1 gnt", int'(gnt_v[0]), 0);
    tick(3'b001, 3'b001, 3'b001);
    check("stall c2 gnt", int'(gnt_v[0]), 0);
    tick(3'b001, 3'b001, 3'b001);
    check("stall c3 gnt", int'(gnt_v[0]), 1);
    repeat (3) tick(3'b001, 3'b000, 3'b000);
    check("stall cnt", int'(cnt_a), 2);

    // MIN_LAT=2: stall 1..2 then low -> gnt 3
    tick(3'b010, 3'b010, 3'b000);
    tick(3'b010, 3'b010, 3'b010);
    check("min2 a c1 gnt", int'(gnt_v[1]), 0);
    tick(3'b010, 3'b010, 3'b010);
    check("min2 a c2 gnt", int'(gnt_v[1]), 0);
    tick(3'b010, 3'b010, 3'b000);
    check("min2 a c3 gnt", int'(gnt_v[1]), 1);
    repeat (3) tick(3'b010, 3'b000, 3'b000);
    // MIN_LAT=2, stall low throughout: held off at 1, granted at 2
    tick(3'b010, 3'b010, 3'b000);
    tick(3'b010, 3'b010, 3'b000);
    check("min2 b c1 gnt", int'(gnt_v[1]), 0);
    tick(3'b010, 3'b010, 3'b000);
    check("min2 b c2 gnt", int'(gnt_v[1]), 1);
    repeat (3) tick(3'b010, 3'b000, 3'b000);
    check("min2 cnt", int'(cnt_b), 2);

    // req dropped before grant -> sticky violation
    tick(3'b001, 3'b001, 3'b001);
    tick(3'b001, 3'b001, 3'b001);
    tick(3'b001, 3'b000, 3'b001);
    check("viol c2 gnt", int'(gnt_v[0]), 0);
    check("viol c2 ok", int'(ok_v[0]), 1);
    tick(3'b001, 3'b000, 3'b000);
    check("viol c3 ok", int'(ok_v[0]), 0);
    check("viol c3 err", int'(err_v[0]), 1);
    check("viol c3 busy", int'(busy_v[0]), 0);
    tick(3'b001, 3'b001, 3'b000);
    tick(3'b001, 3'b001, 3'b000);
    check("post-viol gnt", int'(gnt_v[0]), 1);
    repeat (3) tick(3'b001, 3'b000, 3'b000);
    check("post-viol err", int'(err_v[0]), 1);
    check("post-viol cnt", int'(cnt_a), 3);

    // en low blocks acceptance; grant one cycle after en rises
    for (int k = 0; k < 5; k++) begin
      tick(3'b000, 3'b001, 3'b000);
      check("en0 gnt", int'(gnt_v[0]), 0);
      check("en0 busy", int'(busy_v[0]), 0);
    end
    tick(3'b001, 3'b001, 3'b000);
    check("en rise c0 gnt", int'(gnt_v[0]), 0);
    tick(3'b001, 3'b001, 3'b000);
    check("en rise c1 gnt", int'(gnt_v[0]), 1);
    repeat (3) tick(3'b001, 3'b000, 3'b000);
    check("en rise cnt", int'(cnt_a), 4);

    // CNT_W=2 saturation, no cooldown
    for (int k = 1; k <= 5; k++) begin
      tick(3'b100, 3'b100, 3'b000);
      tick(3'b100, 3'b100, 3'b000);
      check("sat gnt", int'(gnt_v[2]), 1);
      tick(3'b100, 3'b000, 3'b000);
      check("sat busy", int'(busy_v[2]), 0);
      check($sformatf("sat cnt after %0d", k), int'(cnt_c), (k < 3) ? k : 3);
    end

    // asynchronous reset in the middle of WAIT
    tick(3'b100, 3'b100, 3'b000);
    tick(3'b100, 3'b100, 3'b100);
    check("pre-rst busy", int'(busy_v[2]), 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async rst gnt", int'(gnt_v[2]), 0);
    check("async rst busy", int'(busy_v[2]), 0);
    check("async rst cnt", int'(cnt_c), 0);
    check("async rst ok", int'(ok_v[0]), 1);
    check("async rst err", int'(err_v[0]), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1; en_v = 3'b000; req_v = 3'b000; stall_v = 3'b000;
    tick(3'b000, 3'b000, 3'b000);
    tick(3'b000, 3'b000, 3'b000);
    check("post-rst cnt", int'(cnt_a), 0);
    check("post-rst ok", int'(ok_v[0]), 1);

    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
